riscv_axi_lite_regs: RTL and testbench

RISCV_AXI_LITE_REGS -- requirements
Module: riscv_axi_lite_regs

---
 rtl/riscv_axi_lite_pkg.sv | 47 ++++
 rtl/riscv_axi_lite_hold.sv | 46 ++++
 rtl/riscv_axi_lite_regs.sv | 215 +++++++++++++++++++++
 tb/tb_riscv_axi_lite_regs.sv | 349 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_axi_lite_pkg.sv
// ---------------------------------------------------------------------------
// riscv_axi_lite_pkg
// Shared definitions for the AXI4-Lite register slice that exposes four
// 32-bit control words to the RISC-V core.
//   RESP_OKAY        : the only response this slave ever returns
//   REG_IDX_0..3     : word indices taken from address bits [3:2]
//   wr_state_t       : write channel FSM states
//   rd_state_t       : read channel FSM states
//   mergeStrobe()    : byte-lane merge of new write data into an old word
// ---------------------------------------------------------------------------
package riscv_axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  localparam logic [1:0] REG_IDX_0 = 2'd0;
  localparam logic [1:0] REG_IDX_1 = 2'd1;
  localparam logic [1:0] REG_IDX_2 = 2'd2;
  localparam logic [1:0] REG_IDX_3 = 2'd3;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_HAVE_AW,
    WR_HAVE_W,
    WR_RESP
  } wr_state_t;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_t;

  // Replace only the byte lanes whose strobe bit is set; a zero strobe
  // leaves the old word untouched.
  function automatic logic [31:0] mergeStrobe(input logic [31:0] oldWord,
                                              input logic [31:0] newWord,
                                              input logic [3:0]  strb);
    logic [31:0] result;
    result = oldWord;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) begin
        result[8*b +: 8] = newWord[8*b +: 8];
      end
    end
    return result;
  endfunction

endpackage

// File: rtl/riscv_axi_lite_hold.sv
// ---------------------------------------------------------------------------
// riscv_axi_lite_hold
// One-entry holding buffer used to park an accepted AW or W beat until its
// partner arrives.
//   clk_i   : clock, rising edge
//   rst_i   : synchronous active-high reset, empties the buffer
//   load_i  : handshake seen this cycle, capture data_i
//   clear_i : contents consumed, mark empty
//   data_i  : payload to capture
//   valid_o : buffer holds a payload
//   data_o  : held payload
// ---------------------------------------------------------------------------
module riscv_axi_lite_hold #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q;
  logic [WIDTH-1:0] data_q;

  // Load and clear never coincide: the upstream READY is low while the
  // buffer is full, and the buffer is only cleared while full. Reset drops
  // whatever was parked so a half-finished write is simply forgotten.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (clear_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/riscv_axi_lite_regs.sv
// ---------------------------------------------------------------------------
// riscv_axi_lite_regs
// AXI4-Lite slave holding four read/write 32-bit registers for the core.
//   ACLK, ARESET           : clock (rising edge), synchronous active-high reset
//   S_AXI_AW* / S_AXI_W*   : write address / data channels, accepted
//                            independently into one-entry buffers
//   S_AXI_B*               : write response, always OKAY
//   S_AXI_AR* / S_AXI_R*   : read address / data channels, latency 1
//   reg0_o..reg3_o         : current register contents
//   wr_pulse_o             : one-cycle strobe per register written
// ---------------------------------------------------------------------------
module riscv_axi_lite_regs
  import riscv_axi_lite_pkg::*;
#(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                            ACLK,
  input  logic                            ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
  input  logic [2:0]                      S_AXI_AWPROT,
  input  logic                            S_AXI_AWVALID,
  output logic                            S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
  input  logic                            S_AXI_WVALID,
  output logic                            S_AXI_WREADY,
  output logic [1:0]                      S_AXI_BRESP,
  output logic                            S_AXI_BVALID,
  input  logic                            S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
  input  logic [2:0]                      S_AXI_ARPROT,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg0_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg1_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg2_o,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   reg3_o,
  output logic [3:0]                      wr_pulse_o
);

  localparam int STRB_W = C_S_AXI_DATA_WIDTH / 8;
  localparam int WBUF_W = C_S_AXI_DATA_WIDTH + STRB_W;

  logic                          active_q;
  wr_state_t                     wrState_q;
  rd_state_t                     rdState_q;
  logic [C_S_AXI_DATA_WIDTH-1:0] regs_q [4];
  logic [C_S_AXI_DATA_WIDTH-1:0] rdata_q;
  logic                          bvalid_q;
  logic                          rvalid_q;
  logic [3:0]                    wrPulse_q;

  logic                          awFull;
  logic [1:0]                    awIdx;
  logic                          wFull;
  logic [WBUF_W-1:0]             wHeld;
  logic [C_S_AXI_DATA_WIDTH-1:0] wDataHeld;
  logic [STRB_W-1:0]             wStrbHeld;

  logic                          awHs;
  logic                          wHs;
  logic                          arHs;
  logic                          bHs;
  logic                          doUpdate;
  logic [1:0]                    arIdx;
  logic [C_S_AXI_DATA_WIDTH-1:0] mergedWord_d;
  logic [3:0]                    wrPulse_d;
  logic                          unusedBits;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unusedBits = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // active_q keeps every READY low during reset and for the edge on which
  // reset is released, so the master never sees READY before the first
  // cycle after ARESET falls.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      active_q <= 1'b0;
    end else begin
      active_q <= 1'b1;
    end
  end

  assign S_AXI_AWREADY = active_q && !awFull && (wrState_q != WR_RESP);
  assign S_AXI_WREADY  = active_q && !wFull  && (wrState_q != WR_RESP);
  assign S_AXI_ARREADY = active_q && (rdState_q == RD_IDLE);

  assign awHs  = S_AXI_AWVALID && S_AXI_AWREADY;
  assign wHs   = S_AXI_WVALID  && S_AXI_WREADY;
  assign arHs  = S_AXI_ARVALID && S_AXI_ARREADY;
  assign bHs   = bvalid_q      && S_AXI_BREADY;
  assign arIdx = S_AXI_ARADDR[3:2];

  riscv_axi_lite_hold #(.WIDTH(2)) uAwHold (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .load_i  (awHs),
    .clear_i (doUpdate),
    .data_i  (S_AXI_AWADDR[3:2]),
    .valid_o (awFull),
    .data_o  (awIdx)
  );

  riscv_axi_lite_hold #(.WIDTH(WBUF_W)) uWHold (
    .clk_i   (ACLK),
    .rst_i   (ARESET),
    .load_i  (wHs),
    .clear_i (doUpdate),
    .data_i  ({S_AXI_WSTRB, S_AXI_WDATA}),
    .valid_o (wFull),
    .data_o  (wHeld)
  );

  assign wDataHeld = wHeld[C_S_AXI_DATA_WIDTH-1:0];
  assign wStrbHeld = wHeld[WBUF_W-1:C_S_AXI_DATA_WIDTH];

  // The commit happens on the edge after the second buffer fills, which
  // keeps the register write and BVALID one cycle behind the last handshake.
  assign doUpdate = awFull && wFull && (wrState_q != WR_RESP);

  // Next register value and the strobe for the addressed word.
  always_comb begin
    mergedWord_d = mergeStrobe(regs_q[awIdx], wDataHeld, wStrbHeld);
    wrPulse_d    = 4'b0001 << awIdx;
  end

  // Write channel: states track which half of the transaction is parked.
  // When both arrive together the FSM goes to WR_HAVE_AW with both buffers
  // full and commits on the following edge like any other ordering.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      wrState_q <= WR_IDLE;
      bvalid_q  <= 1'b0;
      wrPulse_q <= 4'b0000;
      for (int i = 0; i < 4; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      wrPulse_q <= 4'b0000;
      case (wrState_q)
        WR_IDLE: begin
          if (awHs) begin
            wrState_q <= WR_HAVE_AW;
          end else if (wHs) begin
            wrState_q <= WR_HAVE_W;
          end
        end
        WR_HAVE_AW, WR_HAVE_W: begin
          if (doUpdate) begin
            regs_q[awIdx] <= mergedWord_d;
            wrPulse_q     <= wrPulse_d;
            bvalid_q      <= 1'b1;
            wrState_q     <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (bHs) begin
            bvalid_q  <= 1'b0;
            wrState_q <= WR_IDLE;
          end
        end
        default: begin
          wrState_q <= WR_IDLE;
        end
      endcase
    end
  end

  // Read channel: data is captured on the AR handshake from the current
  // register contents, so a write committing on the same edge is not seen.
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      rdState_q <= RD_IDLE;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
    end else begin
      case (rdState_q)
        RD_IDLE: begin
          if (arHs) begin
            rdata_q   <= regs_q[arIdx];
            rvalid_q  <= 1'b1;
            rdState_q <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (S_AXI_RREADY) begin
            rvalid_q  <= 1'b0;
            rdState_q <= RD_IDLE;
          end
        end
        default: begin
          rdState_q <= RD_IDLE;
        end
      endcase
    end
  end

  assign S_AXI_BRESP  = RESP_OKAY;
  assign S_AXI_BVALID = bvalid_q;
  assign S_AXI_RDATA  = rdata_q;
  assign S_AXI_RRESP  = RESP_OKAY;
  assign S_AXI_RVALID = rvalid_q;

  assign reg0_o     = regs_q[REG_IDX_0];
  assign reg1_o     = regs_q[REG_IDX_1];
  assign reg2_o     = regs_q[REG_IDX_2];
  assign reg3_o     = regs_q[REG_IDX_3];
  assign wr_pulse_o = wrPulse_q;

endmodule

// File: tb/tb_riscv_axi_lite_regs.sv
// ---------------------------------------------------------------------------
// tb_riscv_axi_lite_regs
// Directed bench for the AXI4-Lite register slice. Expected B and R
// responses are queued when a transaction is issued; a monitor pops and
// compares them whenever a response handshake is seen.
// ---------------------------------------------------------------------------
module tb_riscv_axi_lite_regs;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic [3:0]  S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b1;
  logic [3:0]  S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b1;
  logic [31:0] reg0_o;
  logic [31:0] reg1_o;
  logic [31:0] reg2_o;
  logic [31:0] reg3_o;
  logic [3:0]  wr_pulse_o;

  int testsRun = 0;
  int testsFailed = 0;

  logic [1:0]  bQ [$];
  logic [31:0] rQ [$];
  logic [1:0]  expB;
  logic [31:0] expR;

  riscv_axi_lite_regs #(
    .C_S_AXI_DATA_WIDTH (32),
    .C_S_AXI_ADDR_WIDTH (4)
  ) dut (
    .ACLK          (ACLK),
    .ARESET        (ARESET),
    .S_AXI_AWADDR  (S_AXI_AWADDR),
    .S_AXI_AWPROT  (S_AXI_AWPROT),
    .S_AXI_AWVALID (S_AXI_AWVALID),
    .S_AXI_AWREADY (S_AXI_AWREADY),
    .S_AXI_WDATA   (S_AXI_WDATA),
    .S_AXI_WSTRB   (S_AXI_WSTRB),
    .S_AXI_WVALID  (S_AXI_WVALID),
    .S_AXI_WREADY  (S_AXI_WREADY),
    .S_AXI_BRESP   (S_AXI_BRESP),
    .S_AXI_BVALID  (S_AXI_BVALID),
    .S_AXI_BREADY  (S_AXI_BREADY),
    .S_AXI_ARADDR  (S_AXI_ARADDR),
    .S_AXI_ARPROT  (S_AXI_ARPROT),
    .S_AXI_ARVALID (S_AXI_ARVALID),
    .S_AXI_ARREADY (S_AXI_ARREADY),
    .S_AXI_RDATA   (S_AXI_RDATA),
    .S_AXI_RRESP   (S_AXI_RRESP),
    .S_AXI_RVALID  (S_AXI_RVALID),
    .S_AXI_RREADY  (S_AXI_RREADY),
    .reg0_o        (reg0_o),
    .reg1_o        (reg1_o),
    .reg2_o        (reg2_o),
    .reg3_o        (reg3_o),
    .wr_pulse_o    (wr_pulse_o)
  );

  // 100 MHz free-running clock.
  always #5 ACLK = ~ACLK;

  // Single point where every comparison is counted and reported.
  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  // Advance to just after the next rising edge, where inputs are changed.
  task automatic step();
    @(posedge ACLK);
    #1;
  endtask

  // Full write with AW and W presented together; the B response is left to
  // the monitor.
  task automatic axiWrite(input logic [3:0] addr, input logic [31:0] data,
                          input logic [3:0] strb);
    bit awDone;
    bit wDone;
    bit awHs;
    bit wHs;
    int n;
    bQ.push_back(2'b00);
    S_AXI_AWADDR  = addr;
    S_AXI_AWVALID = 1'b1;
    S_AXI_WDATA   = data;
    S_AXI_WSTRB   = strb;
    S_AXI_WVALID  = 1'b1;
    awDone = 1'b0;
    wDone  = 1'b0;
    n      = 0;
    while (!(awDone && wDone) && n < 40) begin
      @(negedge ACLK);
      awHs = S_AXI_AWVALID && S_AXI_AWREADY;
      wHs  = S_AXI_WVALID && S_AXI_WREADY;
      step();
      if (awHs) begin
        S_AXI_AWVALID = 1'b0;
        awDone = 1'b1;
      end
      if (wHs) begin
        S_AXI_WVALID = 1'b0;
        wDone = 1'b1;
      end
      n++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    checkOutput("wr_handshake_in_time", 32'(awDone && wDone), 32'd1);
  endtask

  // Read with the expected data queued; RVALID must follow the AR
  // handshake by exactly one cycle.
  task automatic axiRead(input logic [3:0] addr, input logic [31:0] expData);
    bit arDone;
    bit arHs;
    int n;
    rQ.push_back(expData);
    S_AXI_ARADDR  = addr;
    S_AXI_ARVALID = 1'b1;
    arDone = 1'b0;
    n      = 0;
    while (!arDone && n < 40) begin
      @(negedge ACLK);
      arHs = S_AXI_ARVALID && S_AXI_ARREADY;
      step();
      if (arHs) begin
        S_AXI_ARVALID = 1'b0;
        arDone = 1'b1;
      end
      n++;
    end
    S_AXI_ARVALID = 1'b0;
    checkOutput("rd_handshake_in_time", 32'(arDone), 32'd1);
    @(negedge ACLK);
    checkOutput("rd_latency_rvalid", 32'(S_AXI_RVALID), 32'd1);
    step();
  endtask

  // Response monitor: samples mid-cycle, when inputs and outputs are stable.
  initial begin
    forever begin
      @(negedge ACLK);
      if (S_AXI_BVALID && S_AXI_BREADY) begin
        checkOutput("b_expected_pending", 32'(bQ.size() > 0), 32'd1);
        if (bQ.size() > 0) begin
          expB = bQ.pop_front();
          checkOutput("bresp", 32'(S_AXI_BRESP), 32'(expB));
        end
      end
      if (S_AXI_RVALID && S_AXI_RREADY) begin
        checkOutput("r_expected_pending", 32'(rQ.size() > 0), 32'd1);
        if (rQ.size() > 0) begin
          expR = rQ.pop_front();
          checkOutput("rdata", S_AXI_RDATA, expR);
          checkOutput("rresp", 32'(S_AXI_RRESP), 32'd0);
        end
      end
    end
  end

  // Directed sequence with hand-computed expectations.
  task automatic applyStimulus();
    // Reset values and READY release timing.
    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    checkOutput("reset_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    checkOutput("reset_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    checkOutput("reset_regs", reg0_o | reg1_o | reg2_o | reg3_o, 32'd0);
    checkOutput("reset_pulse", 32'(wr_pulse_o), 32'd0);
    checkOutput("reset_rdata", S_AXI_RDATA, 32'd0);
    step();
    ARESET = 1'b0;
    @(negedge ACLK);
    checkOutput("ready_at_reset_fall", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd0);
    step();
    @(negedge ACLK);
    checkOutput("ready_after_reset", 32'({S_AXI_AWREADY, S_AXI_WREADY, S_AXI_ARREADY}), 32'd7);
    step();

    // Basic write then read-back of all four registers.
    axiWrite(4'h0, 32'h1, 4'hF);
    axiWrite(4'h4, 32'h2, 4'hF);
    axiWrite(4'h8, 32'h3, 4'hF);
    axiWrite(4'hC, 32'h4, 4'hF);
    repeat (3) step();
    checkOutput("basic_reg0", reg0_o, 32'h1);
    checkOutput("basic_reg1", reg1_o, 32'h2);
    checkOutput("basic_reg2", reg2_o, 32'h3);
    checkOutput("basic_reg3", reg3_o, 32'h4);
    axiRead(4'h0, 32'h1);
    axiRead(4'h4, 32'h2);
    axiRead(4'h8, 32'h3);
    axiRead(4'hD, 32'h4);

    // Zero strobe: OKAY, pulse on reg3, contents unchanged.
    axiWrite(4'hC, 32'hDEADBEEF, 4'h0);
    @(negedge ACLK);
    @(negedge ACLK);
    checkOutput("zero_strb_pulse", 32'(wr_pulse_o), 32'h8);
    step();
    repeat (3) step();
    checkOutput("zero_strb_reg3", reg3_o, 32'h4);

    // W three cycles ahead of AW to reg2.
    bQ.push_back(2'b00);
    S_AXI_WDATA  = 32'h55;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("w_first_wready", 32'(S_AXI_WREADY), 32'd1);
    step();
    S_AXI_WVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("w_held_ready", 32'({S_AXI_AWREADY, S_AXI_WREADY}), 32'd2);
    step();
    step();
    S_AXI_AWADDR  = 4'h8;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("w_first_awready", 32'(S_AXI_AWREADY), 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("w_first_no_early_b", 32'({S_AXI_BVALID, wr_pulse_o}), 32'd0);
    @(negedge ACLK);
    checkOutput("w_first_bvalid", 32'(S_AXI_BVALID), 32'd1);
    checkOutput("w_first_pulse", 32'(wr_pulse_o), 32'h4);
    checkOutput("w_first_reg2", reg2_o, 32'h55);
    step();
    repeat (3) step();

    // Partial strobe merge on reg1.
    axiWrite(4'h4, 32'hFFFFFFFF, 4'hF);
    axiWrite(4'h4, 32'h12345678, 4'b0101);
    repeat (3) step();
    checkOutput("strb_merge_reg1", reg1_o, 32'hFF34FF78);

    // Back-pressure on B for ten cycles.
    S_AXI_BREADY = 1'b0;
    axiWrite(4'h0, 32'hA5, 4'hF);
    @(negedge ACLK);
    for (int i = 0; i < 10; i++) begin
      @(negedge ACLK);
      checkOutput("b_hold_state", 32'({S_AXI_BVALID, S_AXI_AWREADY, S_AXI_WREADY}), 32'd4);
    end
    step();
    S_AXI_BREADY = 1'b1;
    axiWrite(4'h0, 32'h5A, 4'hF);
    repeat (3) step();
    checkOutput("after_bp_reg0", reg0_o, 32'h5A);

    // Read colliding with a write commit on reg1 returns the old value.
    axiWrite(4'h4, 32'hAA, 4'hF);
    axiRead(4'h4, 32'hFF34FF78);
    repeat (2) step();
    axiRead(4'h4, 32'hAA);
    repeat (2) step();

    // Reset with AW parked and an R response pending.
    S_AXI_RREADY  = 1'b0;
    S_AXI_ARADDR  = 4'h0;
    S_AXI_ARVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("pre_rst_arready", 32'(S_AXI_ARREADY), 32'd1);
    step();
    S_AXI_ARVALID = 1'b0;
    S_AXI_AWADDR  = 4'h0;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("pre_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    @(negedge ACLK);
    checkOutput("pre_rst_rvalid", 32'(S_AXI_RVALID), 32'd1);
    step();
    ARESET = 1'b1;
    step();
    @(negedge ACLK);
    checkOutput("mid_rst_valid", 32'({S_AXI_BVALID, S_AXI_RVALID}), 32'd0);
    checkOutput("mid_rst_regs", reg0_o | reg1_o | reg2_o | reg3_o, 32'd0);
    step();
    ARESET = 1'b0;
    step();
    step();
    S_AXI_RREADY = 1'b1;

    // Only W after reset: the discarded AW must not complete it.
    S_AXI_WDATA  = 32'h77;
    S_AXI_WSTRB  = 4'hF;
    S_AXI_WVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("post_rst_wready", 32'(S_AXI_WREADY), 32'd1);
    step();
    S_AXI_WVALID = 1'b0;
    repeat (3) @(negedge ACLK);
    checkOutput("discarded_aw_no_b", 32'(S_AXI_BVALID), 32'd0);
    checkOutput("discarded_aw_reg0", reg0_o, 32'd0);
    step();
    bQ.push_back(2'b00);
    S_AXI_AWADDR  = 4'h0;
    S_AXI_AWVALID = 1'b1;
    @(negedge ACLK);
    checkOutput("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    step();
    S_AXI_AWVALID = 1'b0;
    repeat (3) step();
    checkOutput("post_rst_reg0", reg0_o, 32'h77);

    repeat (5) step();
    checkOutput("b_queue_drained", 32'(bQ.size()), 32'd0);
    checkOutput("r_queue_drained", 32'(rQ.size()), 32'd0);
  endtask

  initial begin
    applyStimulus();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

  // Hard stop if the sequence ever wedges.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
